// File: rtl/zports.sv
// zports: host-visible control/status registers for the W5300 and SL811 chips,
// covering chip reset pulses, ROM window mapping and an optional interrupt block (ZPORTS_INT_EN).
module zports #(
    parameter int unsigned RST_CYCLES = 200
) (
    input  logic       fclk,
    input  logic       zrst_n,
    input  logic       ports_wrena,
    input  logic       ports_wrstb_n,
    input  logic [1:0] ports_addr,
    input  logic [7:0] ports_wrdata,
    output logic [7:0] ports_rddata,
    output logic [1:0] rommap_win,
    output logic       rommap_ena,
    output logic       w5300_ports,
    output logic       w5300_rst_n,
    output logic       sl811_rst_n,
    input  logic       w5300_int_n,
    input  logic       sl811_intrq,
    output logic       int_n
);

    localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

    logic [2:0] stb_sync_q;
    logic       stb_fall;
    logic       wr_commit;
    logic       wr_ctrl;
    logic       wr_scratch;

    logic [3:0] ctrl_q, ctrl_d;
    logic [7:0] scratch_q, scratch_d;
    logic [7:0] w_cnt_q, w_cnt_d;
    logic [7:0] s_cnt_q, s_cnt_d;
    logic       w_rst_n_q, s_rst_n_q;
    logic [7:0] ctrl_rd;
    logic [7:0] int_rd;

    always_ff @(posedge fclk or negedge zrst_n) begin
        if (!zrst_n) begin
            stb_sync_q <= 3'b111;
        end else begin
            stb_sync_q <= {stb_sync_q[1:0], ports_wrstb_n};
        end
    end

    // One commit per strobe assertion, however long the strobe stays low.
    assign stb_fall   = stb_sync_q[2] & ~stb_sync_q[1];
    assign wr_commit  = stb_fall & ports_wrena;
    assign wr_ctrl    = wr_commit && (ports_addr == 2'd1);
    assign wr_scratch = wr_commit && (ports_addr == 2'd3);

    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        w_cnt_d   = w_cnt_q;
        s_cnt_d   = s_cnt_q;
        if (wr_ctrl) begin
            ctrl_d = ports_wrdata[3:0];
        end
        if (wr_scratch) begin
            scratch_d = ports_wrdata;
        end
        // A start always wins over the decrement, so a restart never lets rst_n blip high.
        if (wr_ctrl && ports_wrdata[7]) begin
            w_cnt_d = RST_LOAD;
        end else if (w_cnt_q != 8'd0) begin
            w_cnt_d = w_cnt_q - 8'd1;
        end
        if (wr_ctrl && ports_wrdata[6]) begin
            s_cnt_d = RST_LOAD;
        end else if (s_cnt_q != 8'd0) begin
            s_cnt_d = s_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge fclk or negedge zrst_n) begin
        if (!zrst_n) begin
            ctrl_q    <= 4'd0;
            scratch_q <= 8'd0;
            w_cnt_q   <= RST_LOAD;
            s_cnt_q   <= RST_LOAD;
            w_rst_n_q <= 1'b0;
            s_rst_n_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            w_cnt_q   <= w_cnt_d;
            s_cnt_q   <= s_cnt_d;
            w_rst_n_q <= (w_cnt_d == 8'd0);
            s_rst_n_q <= (s_cnt_d == 8'd0);
        end
    end

    assign w5300_ports = ctrl_q[0];
    assign rommap_ena  = ctrl_q[1];
    assign rommap_win  = ctrl_q[3:2];
    assign w5300_rst_n = w_rst_n_q;
    assign sl811_rst_n = s_rst_n_q;
    assign ctrl_rd     = {~w_rst_n_q, ~s_rst_n_q, 2'b00, ctrl_q};

`ifdef ZPORTS_INT_EN
    logic       wr_int;
    logic [1:0] w_int_sync_q;
    logic [1:0] s_int_sync_q;
    logic [1:0] int_en_q, int_en_d;
    logic [1:0] int_pend;
    logic       int_n_q;

    assign wr_int   = wr_commit && (ports_addr == 2'd2);
    assign int_pend = {s_int_sync_q[1], ~w_int_sync_q[1]};

    always_comb begin
        int_en_d = int_en_q;
        if (wr_int) begin
            int_en_d = ports_wrdata[5:4];
        end
    end

    always_ff @(posedge fclk or negedge zrst_n) begin
        if (!zrst_n) begin
            w_int_sync_q <= 2'b11;
            s_int_sync_q <= 2'b00;
            int_en_q     <= 2'b00;
            int_n_q      <= 1'b1;
        end else begin
            w_int_sync_q <= {w_int_sync_q[0], w5300_int_n};
            s_int_sync_q <= {s_int_sync_q[0], sl811_intrq};
            int_en_q     <= int_en_d;
            int_n_q      <= ~|(int_pend & int_en_q);
        end
    end

    assign int_rd = {2'b00, int_en_q, 2'b00, int_pend};
    assign int_n  = int_n_q;
`else
    logic unused_int_inputs;

    assign unused_int_inputs = w5300_int_n ^ sl811_intrq;
    assign int_rd            = 8'h00;
    assign int_n             = 1'b1;
`endif

    always_comb begin
        ports_rddata = 8'hFF;
        case (ports_addr)
            2'd0:    ports_rddata = 8'hFF;
            2'd1:    ports_rddata = ctrl_rd;
            2'd2:    ports_rddata = int_rd;
            default: ports_rddata = scratch_q;
        endcase
    end

endmodule
